// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker FSM states and bit-exact LFSR helpers used by both link ends.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package prbs_pkg;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } prbs_state_t;

    localparam int PRBS_MAXW = 64;

    // One Fibonacci step: feedback enters at bit pw-1, S[0] is the bit leaving the register.
    function automatic logic [PRBS_MAXW-1:0] F_prbs_step(
        input logic [PRBS_MAXW-1:0] s,
        input logic [PRBS_MAXW-1:0] taps,
        input int                   pw
    );
        logic fb;
        fb = ^(s & taps);
        return (s >> 1) | (PRBS_MAXW'(fb) << (pw - 1));
    endfunction

    function automatic logic [PRBS_MAXW-1:0] F_prbs_reg(
        input logic [PRBS_MAXW-1:0] s,
        input logic [PRBS_MAXW-1:0] taps,
        input int                   pw,
        input int                   n
    );
        logic [PRBS_MAXW-1:0] r;
        r = s;
        for (int i = 0; i < PRBS_MAXW; i++) begin
            if (i < n) r = F_prbs_step(r, taps, pw);
        end
        return r;
    endfunction

    // First step lands in the MSB of the n-bit word.
    function automatic logic [PRBS_MAXW-1:0] F_prbs_output(
        input logic [PRBS_MAXW-1:0] s,
        input logic [PRBS_MAXW-1:0] taps,
        input int                   pw,
        input int                   n
    );
        logic [PRBS_MAXW-1:0] r;
        logic [PRBS_MAXW-1:0] w;
        r = s;
        w = '0;
        for (int i = 0; i < PRBS_MAXW; i++) begin
            if (i < n) begin
                w[n-1-i] = r[0];
                r = F_prbs_step(r, taps, pw);
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/prbs_popcnt.sv
// Population count of a C_DWIDTH-bit vector.
// Latency: combinational.
// Backpressure: none.
module prbs_popcnt #(
    parameter int C_DWIDTH = 16
) (
    input  logic [C_DWIDTH-1:0]         I_dat,
    output logic [$clog2(C_DWIDTH+1)-1:0] O_cnt
);

    localparam int CW = $clog2(C_DWIDTH + 1);

    always_comb begin
        O_cnt = '0;
        for (int i = 0; i < C_DWIDTH; i++) begin
            O_cnt = O_cnt + CW'(I_dat[i]);
        end
    end

endmodule

// File: rtl/prbs_chk.sv
// Self-synchronising PRBS checker with lock detect and saturating bit-error count; PRBS_CHK_INVERT_EN adds I_inv.
// Latency: 1 cycle from I_prbs_v to O_err_v/O_err_bits; O_lock 1 cycle after the locking word.
// Backpressure: none, always accepts; I_prbs_v=0 freezes all state.
module prbs_chk
    import prbs_pkg::*;
#(
    parameter int                    C_DWIDTH       = 16,
    parameter int                    C_POLY_WIDTH   = 16,
    parameter logic [C_POLY_WIDTH:0] C_PRIMPOLY     = 17'b1_0001_0000_0000_1011,
    parameter int                    C_LOCK_CNT     = 4,
    parameter int                    C_LOSS_THR     = 4,
    parameter int                    C_ERRCNT_WIDTH = 32
) (
    input  logic                          I_clk,
    input  logic                          I_rst,
`ifdef PRBS_CHK_INVERT_EN
    input  logic                          I_inv,
`endif
    input  logic [C_DWIDTH-1:0]           I_prbs,
    input  logic                          I_prbs_v,
    input  logic                          I_clr_cnt,
    output logic                          O_lock,
    output logic                          O_err_v,
    output logic [$clog2(C_DWIDTH+1)-1:0] O_err_bits,
    output logic [C_ERRCNT_WIDTH-1:0]     O_err_cnt
);

    localparam int BW = $clog2(C_DWIDTH + 1);
    localparam int SW = ((C_ERRCNT_WIDTH > BW) ? C_ERRCNT_WIDTH : BW) + 1;
    localparam logic [PRBS_MAXW-1:0] TAPS    = PRBS_MAXW'(C_PRIMPOLY[C_POLY_WIDTH-1:0]);
    localparam logic [7:0]           LOCK_N  = 8'(C_LOCK_CNT);
    localparam logic [7:0]           LOSS_N  = 8'(C_LOSS_THR);
    localparam logic [SW-1:0]        CNT_MAX = SW'({C_ERRCNT_WIDTH{1'b1}});

    prbs_state_t               state, state_nxt;
    logic [C_DWIDTH-1:0]       dat;
    logic [C_DWIDTH-1:0]       exp_word;
    logic [C_POLY_WIDTH-1:0]   seed, seed_adv, s_exp, s_exp_adv, s_exp_nxt;
    logic [7:0]                good_run, good_nxt, bad_run, bad_nxt;
    logic [BW-1:0]             mism;
    logic                      chk, cnt_add;
    logic [SW-1:0]             cnt_sum;
    logic [C_ERRCNT_WIDTH-1:0] cnt_sat;

`ifdef PRBS_CHK_INVERT_EN
    assign dat = I_inv ? ~I_prbs : I_prbs;
`else
    assign dat = I_prbs;
`endif

    // Earliest received bit is the LFSR's S[0], so the seed is the word bit-reversed.
    always_comb begin
        seed = '0;
        for (int j = 0; j < C_POLY_WIDTH; j++) begin
            seed[j] = dat[C_DWIDTH-1-j];
        end
    end

    assign seed_adv  = C_POLY_WIDTH'(F_prbs_reg(PRBS_MAXW'(seed), TAPS, C_POLY_WIDTH, C_DWIDTH));
    assign s_exp_adv = C_POLY_WIDTH'(F_prbs_reg(PRBS_MAXW'(s_exp), TAPS, C_POLY_WIDTH, C_DWIDTH));
    assign exp_word  = C_DWIDTH'(F_prbs_output(PRBS_MAXW'(s_exp), TAPS, C_POLY_WIDTH, C_DWIDTH));

    prbs_popcnt #(.C_DWIDTH(C_DWIDTH)) u_popcnt (
        .I_dat (dat ^ exp_word),
        .O_cnt (mism)
    );

    always_ff @(posedge I_clk) begin
        if (I_rst) state <= ST_SEED;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_exp_nxt = s_exp;
        good_nxt  = good_run;
        bad_nxt   = bad_run;
        chk       = 1'b0;
        cnt_add   = 1'b0;
        if (I_prbs_v) begin
            unique case (state)
                ST_VERIFY: begin
                    chk = 1'b1;
                    if (mism == '0) begin
                        s_exp_nxt = s_exp_adv;
                        good_nxt  = good_run + 8'd1;
                        if (good_run + 8'd1 == LOCK_N) begin
                            state_nxt = ST_LOCKED;
                            bad_nxt   = '0;
                        end
                    end else begin
                        s_exp_nxt = seed_adv;
                        good_nxt  = '0;
                        state_nxt = (seed == '0) ? ST_SEED : ST_VERIFY;
                    end
                end
                ST_LOCKED: begin
                    chk       = 1'b1;
                    cnt_add   = 1'b1;
                    s_exp_nxt = s_exp_adv;
                    if (mism == '0) begin
                        bad_nxt = '0;
                    end else if (bad_run + 8'd1 == LOSS_N) begin
                        bad_nxt   = '0;
                        state_nxt = ST_SEED;
                    end else begin
                        bad_nxt = bad_run + 8'd1;
                    end
                end
                default: begin
                    s_exp_nxt = seed_adv;
                    good_nxt  = '0;
                    bad_nxt   = '0;
                    state_nxt = (seed == '0) ? ST_SEED : ST_VERIFY;
                end
            endcase
        end
    end

    assign cnt_sum = SW'(O_err_cnt) + SW'(mism);
    assign cnt_sat = (cnt_sum > CNT_MAX) ? '1 : C_ERRCNT_WIDTH'(cnt_sum);

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            s_exp      <= '0;
            good_run   <= '0;
            bad_run    <= '0;
            O_err_v    <= 1'b0;
            O_err_bits <= '0;
            O_err_cnt  <= '0;
        end else begin
            s_exp    <= s_exp_nxt;
            good_run <= good_nxt;
            bad_run  <= bad_nxt;
            O_err_v  <= chk;
            if (chk) O_err_bits <= mism;
            if (I_clr_cnt)    O_err_cnt <= '0;
            else if (cnt_add) O_err_cnt <= cnt_sat;
        end
    end

    assign O_lock = (state == ST_LOCKED);

endmodule

// File: tb/tb_prbs_chk.sv
// Directed bench for prbs_chk: lock, error injection, loss/relock, gaps, clear and saturation.
// Two instances share stimulus; the second has a 4-bit error counter.
module tb_prbs_chk;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, prbs_v, clr_cnt;
    logic [15:0] prbs;
    logic        lock, err_v, lock4, err_v4;
    logic [4:0]  err_bits, err_bits4;
    logic [31:0] err_cnt;
    logic [3:0]  err_cnt4;
`ifdef PRBS_CHK_INVERT_EN
    logic        inv = 1'b0;
`endif

    prbs_chk u_dut (
        .I_clk      (clk),
        .I_rst      (rst),
`ifdef PRBS_CHK_INVERT_EN
        .I_inv      (inv),
`endif
        .I_prbs     (prbs),
        .I_prbs_v   (prbs_v),
        .I_clr_cnt  (clr_cnt),
        .O_lock     (lock),
        .O_err_v    (err_v),
        .O_err_bits (err_bits),
        .O_err_cnt  (err_cnt)
    );

    prbs_chk #(.C_ERRCNT_WIDTH(4)) u_dut4 (
        .I_clk      (clk),
        .I_rst      (rst),
`ifdef PRBS_CHK_INVERT_EN
        .I_inv      (inv),
`endif
        .I_prbs     (prbs),
        .I_prbs_v   (prbs_v),
        .I_clr_cnt  (clr_cnt),
        .O_lock     (lock4),
        .O_err_v    (err_v4),
        .O_err_bits (err_bits4),
        .O_err_cnt  (err_cnt4)
    );

    int          nvec  = 0;
    int          nfail = 0;
    int          exp_cnt;
    int          nv;
    logic        v;
    logic [15:0] g;
    logic [15:0] w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Far-end generator, bit-serial: x^16+x^12+x^3+x+1, first bit out is the MSB.
    task automatic gen_next(output logic [15:0] word);
        logic fb;
        for (int k = 0; k < 16; k++) begin
            word[15-k] = g[0];
            fb = g[0] ^ g[1] ^ g[3] ^ g[12];
            g  = {fb, g[15:1]};
        end
    endtask

    task automatic cyc(input logic [15:0] d, input logic dv, input logic clr, input logic r);
        @(negedge clk);
        prbs    = d;
        prbs_v  = dv;
        clr_cnt = clr;
        rst     = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        g = 16'h0001;
        exp_cnt = 0;

        // reset state
        cyc(16'h0000, 1'b0, 1'b0, 1'b1);
        cyc(16'h0000, 1'b0, 1'b0, 1'b1);
        chk("rst_lock", 64'(lock), 64'd0);
        chk("rst_err_v", 64'(err_v), 64'd0);
        chk("rst_bits", 64'(err_bits), 64'd0);
        chk("rst_cnt", 64'(err_cnt), 64'd0);

        // 1: continuous clean stream, lock after seed + 4
        gen_next(w);
        chk("t1_first_word", 64'(w), 64'h8000);
        cyc(w, 1'b1, 1'b0, 1'b0);
        chk("t1_seed_err_v", 64'(err_v), 64'd0);
        chk("t1_seed_lock", 64'(lock), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            gen_next(w);
            cyc(w, 1'b1, 1'b0, 1'b0);
            chk("t1_err_v", 64'(err_v), 64'd1);
            chk("t1_bits", 64'(err_bits), 64'd0);
            chk("t1_lock", 64'(lock), 64'(k == 4));
        end
        for (int k = 0; k < 3; k++) begin
            gen_next(w);
            cyc(w, 1'b1, 1'b0, 1'b0);
            chk("t1_hold_lock", 64'(lock), 64'd1);
            chk("t1_hold_cnt", 64'(err_cnt), 64'd0);
        end

        // 2: single-bit then 3-bit errors while locked, idle cycle holds bits
        gen_next(w);
        cyc(w ^ 16'h0001, 1'b1, 1'b0, 1'b0);
        chk("t2_bits1", 64'(err_bits), 64'd1);
        chk("t2_cnt1", 64'(err_cnt), 64'd1);
        chk("t2_lock1", 64'(lock), 64'd1);
        cyc(16'hA5A5, 1'b0, 1'b0, 1'b0);
        chk("t2_idle_err_v", 64'(err_v), 64'd0);
        chk("t2_idle_bits", 64'(err_bits), 64'd1);
        gen_next(w);
        cyc(w, 1'b1, 1'b0, 1'b0);
        chk("t2_clean_bits", 64'(err_bits), 64'd0);
        gen_next(w);
        cyc(w ^ 16'h0007, 1'b1, 1'b0, 1'b0);
        chk("t2_bits3", 64'(err_bits), 64'd3);
        chk("t2_cnt4", 64'(err_cnt), 64'd4);
        chk("t2_cnt4_w4", 64'(err_cnt4), 64'd4);
        gen_next(w);
        cyc(w, 1'b1, 1'b0, 1'b0);
        exp_cnt = 4;

        // 3: four zero words drop lock
        for (int k = 0; k < 4; k++) begin
            gen_next(w);
            cyc(16'h0000, 1'b1, 1'b0, 1'b0);
            exp_cnt += $countones(w);
            chk("t3_bits", 64'(err_bits), 64'($countones(w)));
            chk("t3_cnt", 64'(err_cnt), 64'(exp_cnt));
            chk("t3_lock", 64'(lock), 64'(k < 3));
        end

        // 4: zero seeds rejected
        for (int k = 0; k < 3; k++) begin
            cyc(16'h0000, 1'b1, 1'b0, 1'b0);
            chk("t4_zero_err_v", 64'(err_v), 64'd0);
            chk("t4_zero_lock", 64'(lock), 64'd0);
            chk("t4_zero_cnt", 64'(err_cnt), 64'(exp_cnt));
        end

        // relock from live generator
        gen_next(w);
        cyc(w, 1'b1, 1'b0, 1'b0);
        chk("t3_reseed_err_v", 64'(err_v), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            gen_next(w);
            cyc(w, 1'b1, 1'b0, 1'b0);
            chk("t3_relock_err_v", 64'(err_v), 64'd1);
            chk("t3_relock_bits", 64'(err_bits), 64'd0);
            chk("t3_relock", 64'(lock), 64'(k == 4));
        end
        chk("t3_relock_cnt", 64'(err_cnt), 64'(exp_cnt));

        // 5: reset with a valid word present, then gapped stream
        cyc(16'hFFFF, 1'b1, 1'b0, 1'b1);
        chk("t5_rst_lock", 64'(lock), 64'd0);
        chk("t5_rst_cnt", 64'(err_cnt), 64'd0);
        nv = 0;
        for (int i = 0; i < 60; i++) begin
            v = ($urandom_range(0, 1) == 1) || (i % 4 == 0);
            if (v) begin
                gen_next(w);
                nv++;
                cyc(w, 1'b1, 1'b0, 1'b0);
            end else begin
                cyc(16'($urandom), 1'b0, 1'b0, 1'b0);
            end
            chk("t5_err_v", 64'(err_v), 64'(v && nv >= 2));
            chk("t5_bits", 64'(err_bits), 64'd0);
            chk("t5_lock", 64'(lock), 64'(nv >= 5));
        end
        chk("t5_cnt", 64'(err_cnt), 64'd0);
        gen_next(w);
        cyc(w ^ 16'h0001, 1'b1, 1'b0, 1'b0);
        chk("t5_pre_clr_cnt", 64'(err_cnt), 64'd1);
        gen_next(w);
        cyc(w ^ 16'h0300, 1'b1, 1'b1, 1'b0);
        chk("t5_clr_bits", 64'(err_bits), 64'd2);
        chk("t5_clr_cnt", 64'(err_cnt), 64'd0);
        chk("t5_clr_cnt_w4", 64'(err_cnt4), 64'd0);
        gen_next(w);
        cyc(w, 1'b1, 1'b0, 1'b0);
        chk("t5_post_clr_cnt", 64'(err_cnt), 64'd0);

        // 6: saturation on the 4-bit counter
        gen_next(w);
        cyc(w ^ 16'h0FFF, 1'b1, 1'b0, 1'b0);
        chk("t6_bits12", 64'(err_bits4), 64'd12);
        chk("t6_cnt12_w4", 64'(err_cnt4), 64'd12);
        gen_next(w);
        cyc(w ^ 16'h0007, 1'b1, 1'b0, 1'b0);
        chk("t6_cnt15_w4", 64'(err_cnt4), 64'd15);
        chk("t6_cnt15", 64'(err_cnt), 64'd15);
        gen_next(w);
        cyc(w, 1'b1, 1'b0, 1'b0);
        gen_next(w);
        cyc(w ^ 16'h0001, 1'b1, 1'b0, 1'b0);
        chk("t6_sat1_w4", 64'(err_cnt4), 64'hF);
        chk("t6_cnt16", 64'(err_cnt), 64'd16);
        gen_next(w);
        cyc(w ^ 16'h001F, 1'b1, 1'b0, 1'b0);
        chk("t6_sat5_w4", 64'(err_cnt4), 64'hF);
        chk("t6_bits5", 64'(err_bits), 64'd5);
        chk("t6_cnt21", 64'(err_cnt), 64'd21);
        chk("t6_lock_w4", 64'(lock4), 64'd1);
        gen_next(w);
        cyc(w, 1'b1, 1'b0, 1'b0);

        // reset mid-LOCKED with an errored word in the same cycle
        gen_next(w);
        cyc(w ^ 16'h00FF, 1'b1, 1'b0, 1'b1);
        chk("t6_rst_lock", 64'(lock), 64'd0);
        chk("t6_rst_err_v", 64'(err_v), 64'd0);
        chk("t6_rst_bits", 64'(err_bits), 64'd0);
        chk("t6_rst_cnt", 64'(err_cnt), 64'd0);
        chk("t6_rst_cnt_w4", 64'(err_cnt4), 64'd0);
        gen_next(w);
        cyc(w, 1'b1, 1'b0, 1'b0);
        chk("t6_seed_err_v", 64'(err_v), 64'd0);
        chk("t6_seed_lock", 64'(lock), 64'd0);
        gen_next(w);
        cyc(w, 1'b1, 1'b0, 1'b0);
        chk("t6_verify_err_v", 64'(err_v), 64'd1);
        chk("t6_verify_bits", 64'(err_bits), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
